// File: rtl/chaos_sbox_gen.sv
// ---------------------------------------------------------------------------
// chaos_sbox_gen
//
// Builds a 256-entry byte permutation (an S-box) from a chaotic sequence.
// A 16-bit fixed-point logistic map x <- r*x*(1-x) is iterated from a seed.
// Each iteration folds the state into one byte by XORing its high and low
// halves. Bytes already issued are rejected. After MAX_ITER map iterations
// an ascending fill pass issues whatever bytes are still missing, so every
// run ends with exactly 256 distinct bytes.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (honoured only when idle or done)
//   seed[15:0]   in   initial map state x0 in Q0.16, sampled with start
//   enable_write out  one-cycle strobe: data_out carries a new S-box byte
//   data_out[7:0]out  S-box byte, held until the next strobe
//   count[8:0]   out  bytes issued in this run (0..256)
//   busy         out  run in progress
//   done         out  all 256 bytes issued; held until the next start
// ---------------------------------------------------------------------------
module chaos_sbox_gen #(
    parameter logic [15:0] R_COEF   = 16'hFF5C,  // r in unsigned Q2.14 (3.99)
    parameter int unsigned MAX_ITER = 4096,      // 1..65535
    parameter logic [15:0] ZERO_SUB = 16'h5A5A   // replaces a zero state
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        enable_write,
    output logic [7:0]  data_out,
    output logic [8:0]  count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_CHECK,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX_ITER_W = 16'(MAX_ITER);

    state_t        state_q, state_d;
    logic [15:0]   x_q, x_d;        // map state, Q0.16
    logic [15:0]   t_q, t_d;        // x*(1-x), upper half of the product
    logic [15:0]   iter_q, iter_d;
    logic [8:0]    ptr_q, ptr_d;    // fill-pass scan pointer
    logic [255:0]  used_q, used_d;  // one bit per byte already issued
    logic [8:0]    count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          ew_q, ew_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Arithmetic datapath. The map is split over two cycles so that only one
    // multiplier is on any single path.
    logic [16:0]   one_minus_x;     // 65536 - x, needs 17 bits for x == 0
    logic [15:0]   p_hi;            // (x * (65536 - x))[31:16]
    logic [15:0]   xn;              // (t * R_COEF)[29:14]
    logic [7:0]    cand;

    assign one_minus_x = 17'h10000 - {1'b0, x_q};
    assign p_hi = 16'(({16'b0, x_q} * {15'b0, one_minus_x}) >> 16);
    assign xn   = 16'(({16'b0, t_q} * {16'b0, R_COEF}) >> 14);
    assign cand = x_q[15:8] ^ x_q[7:0];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        t_d     = t_q;
        iter_d  = iter_q;
        ptr_d   = ptr_q;
        used_d  = used_q;
        count_d = count_q;
        data_d  = data_q;
        ew_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    used_d  = '0;
                    count_d = '0;
                    iter_d  = '0;
                    x_d     = (seed == 16'h0000) ? ZERO_SUB : seed;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: begin
                t_d     = p_hi;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                // Zero is a fixed point of the map; kick it out.
                x_d     = (xn == 16'h0000) ? ZERO_SUB : xn;
                iter_d  = iter_q + 16'd1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!used_q[cand]) begin
                    data_d       = cand;
                    ew_d         = 1'b1;
                    used_d[cand] = 1'b1;
                    count_d      = count_q + 9'd1;
                end
                if (count_d == 9'd256) begin
                    state_d = S_DONE;
                end else if (iter_q == MAX_ITER_W) begin
                    ptr_d   = '0;
                    state_d = S_FILL;
                end else begin
                    state_d = S_MUL1;
                end
            end
            S_FILL: begin
                if (!used_q[ptr_q[7:0]]) begin
                    data_d               = ptr_q[7:0];
                    ew_d                 = 1'b1;
                    used_d[ptr_q[7:0]]   = 1'b1;
                    count_d              = count_q + 9'd1;
                end
                ptr_d = ptr_q + 9'd1;
                // The scan always finds the last missing byte before ptr
                // wraps, since count < 256 guarantees one is still clear.
                if (count_d == 9'd256) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they change on
        // the same edge as the state itself (done rises with the last strobe).
        busy_d = (state_d == S_MUL1) || (state_d == S_MUL2) ||
                 (state_d == S_CHECK) || (state_d == S_FILL);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            t_q     <= '0;
            iter_q  <= '0;
            ptr_q   <= '0;
            used_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ew_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            t_q     <= t_d;
            iter_q  <= iter_d;
            ptr_q   <= ptr_d;
            used_q  <= used_d;
            count_q <= count_d;
            data_q  <= data_d;
            ew_q    <= ew_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign enable_write = ew_q;
    assign data_out     = data_q;
    assign count        = count_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
